// File: rtl/perceptron_infer.sv
// Perceptron inference: loadable weights/bias, one signed MAC per feature beat,
// step-activation class and raw score returned over a valid/ready handshake.
module perceptron_infer #(
    parameter int unsigned INP_DIM = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 20,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned AW     = $clog2(INP_DIM + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_wr_en,
    input  logic [AW-1:0]            w_wr_addr,
    input  logic signed [DATA_W-1:0] w_wr_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic                     y_class,
    output logic signed [ACC_W-1:0]  y_score,
    output logic                     busy,
    output logic [CNT_W-1:0]         sample_cnt
);

    localparam int unsigned IW = (INP_DIM > 1) ? $clog2(INP_DIM) : 1;
    // Weight array rounded up to a power of two so r_idx always selects in range.
    localparam int unsigned NW = 1 << IW;
    localparam int unsigned PW = 2 * DATA_W;

    typedef enum logic {StAccum, StHold} state_e;

    state_e                     r_state;
    state_e                     w_state_next;
    logic signed [DATA_W-1:0]   r_w [NW];
    logic signed [DATA_W-1:0]   r_bias;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    r_score;
    logic                       r_class;
    logic [IW-1:0]              r_idx;
    logic [CNT_W-1:0]           r_cnt;

    logic                       w_beat;
    logic                       w_last;
    logic                       w_done;
    logic signed [PW-1:0]       w_prod;
    logic signed [ACC_W-1:0]    w_base;
    logic signed [ACC_W-1:0]    w_sum;

    assign w_beat = s_valid && (r_state == StAccum);
    assign w_last = (r_idx == IW'(INP_DIM - 1));
    assign w_done = (r_state == StHold) && y_ready;
    assign w_prod = PW'(s_data) * PW'(r_w[r_idx]);
    assign w_base = (r_idx == '0) ? ACC_W'(r_bias) : r_acc;
    assign w_sum  = w_base + ACC_W'(w_prod);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StAccum: if (w_beat && w_last) w_state_next = StHold;
            StHold:  if (y_ready)          w_state_next = StAccum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StAccum;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Weight writes land at the edge, so a same-cycle MAC still sees the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) r_w[k] <= '0;
            r_bias <= '0;
        end else if (w_wr_en) begin
            for (int k = 0; k < INP_DIM; k++) begin
                if (w_wr_addr == AW'(k)) r_w[k] <= w_wr_data;
            end
            if (w_wr_addr == AW'(INP_DIM)) r_bias <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_score <= '0;
            r_class <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_beat) begin
                if (w_last) begin
                    r_score <= w_sum;
                    r_class <= !w_sum[ACC_W-1] && (w_sum != '0);
                    r_idx   <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (w_done) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign s_ready    = (r_state == StAccum);
    assign y_valid    = (r_state == StHold);
    assign y_class    = r_class;
    assign y_score    = r_score;
    assign busy       = (r_idx != '0) || (r_state == StHold);
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_perceptron_infer.sv
// Directed bench for perceptron_infer: vector table plus handshake, collision,
// reset and counter-wrap sequences.
module tb_perceptron_infer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               w_wr_en;
    logic [1:0]         w_wr_addr;
    logic signed [7:0]  w_wr_data;
    logic               s_valid;
    logic               s_ready;
    logic signed [7:0]  s_data;
    logic               y_valid;
    logic               y_ready;
    logic               y_class;
    logic signed [19:0] y_score;
    logic               busy;
    logic [15:0]        sample_cnt;

    // Second instance: single feature, narrow counter so wrap is reachable quickly.
    logic               w2_wr_en;
    logic [0:0]         w2_wr_addr;
    logic signed [7:0]  w2_wr_data;
    logic               s2_valid;
    logic               s2_ready;
    logic signed [7:0]  s2_data;
    logic               y2_valid;
    logic               y2_ready;
    logic               y2_class;
    logic signed [19:0] y2_score;
    logic               busy2;
    logic [3:0]         sample_cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    perceptron_infer #(.INP_DIM(2), .DATA_W(8), .ACC_W(20), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_class(y_class), .y_score(y_score),
        .busy(busy), .sample_cnt(sample_cnt)
    );

    perceptron_infer #(.INP_DIM(1), .DATA_W(8), .ACC_W(20), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n),
        .w_wr_en(w2_wr_en), .w_wr_addr(w2_wr_addr), .w_wr_data(w2_wr_data),
        .s_valid(s2_valid), .s_ready(s2_ready), .s_data(s2_data),
        .y_valid(y2_valid), .y_ready(y2_ready), .y_class(y2_class), .y_score(y2_score),
        .busy(busy2), .sample_cnt(sample_cnt2)
    );

    typedef struct {
        int w0; int w1; int b; int x0; int x1; int s; int c;
    } vec_t;
    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    task automatic wr(input int addr, input int data);
        w_wr_en   = 1'b1;
        w_wr_addr = 2'(addr);
        w_wr_data = 8'(data);
        tick();
        w_wr_en   = 1'b0;
    endtask

    task automatic load(input int w0, input int w1, input int b);
        wr(0, w0);
        wr(1, w1);
        wr(2, b);
    endtask

    task automatic hs(input string nm);
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 65536;
        chk({nm, "_cnt"}, int'(sample_cnt), exp_cnt);
        chk({nm, "_yv_drop"}, int'(y_valid), 0);
        chk({nm, "_srdy"}, int'(s_ready), 1);
    endtask

    task automatic run_sample(input string nm, input int x0, input int x1,
                              input int es, input int ec);
        s_valid = 1'b1;
        s_data  = 8'(x0);
        tick();
        chk({nm, "_busy_mid"}, int'(busy), 1);
        chk({nm, "_yv_early"}, int'(y_valid), 0);
        s_data = 8'(x1);
        tick();
        s_valid = 1'b0;
        chk({nm, "_yv"}, int'(y_valid), 1);
        chk({nm, "_score"}, int'(y_score), es);
        chk({nm, "_class"}, int'(y_class), ec);
        hs(nm);
    endtask

    initial begin
        vecs[0] = '{4, 9, 0, 2, 3, 35, 1};
        vecs[1] = '{-4, 1, 0, 2, 3, -5, 0};
        vecs[2] = '{-4, 1, 5, 2, 3, 0, 0};
        vecs[3] = '{-4, 1, 6, 2, 3, 1, 1};
        vecs[4] = '{-128, -128, -128, -128, -128, 32640, 1};
        vecs[5] = '{-128, -128, -128, 127, 127, -32640, 0};
        vecs[6] = '{1, 1, -1, 0, 0, -1, 0};

        rst_n = 1'b0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        s_valid = 1'b0; s_data = '0; y_ready = 1'b0;
        w2_wr_en = 1'b0; w2_wr_addr = '0; w2_wr_data = '0;
        s2_valid = 1'b0; s2_data = '0; y2_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_srdy", int'(s_ready), 1);
        chk("rst_yv", int'(y_valid), 0);
        chk("rst_class", int'(y_class), 0);
        chk("rst_score", int'(y_score), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(sample_cnt), 0);

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].w0, vecs[i].w1, vecs[i].b);
            run_sample($sformatf("vec%0d", i), vecs[i].x0, vecs[i].x1, vecs[i].s, vecs[i].c);
        end

        // Address beyond bias must not land anywhere.
        load(1, 1, 0);
        wr(3, 100);
        run_sample("oob_wr", 2, 3, 5, 1);

        // Backpressure: hold result while s_valid stays high with x=7.
        load(4, 9, 0);
        s_valid = 1'b1;
        s_data  = 8'sd2;
        tick();
        s_data = 8'sd3;
        tick();
        s_data = 8'sd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_srdy", int'(s_ready), 0);
            chk("bp_yv", int'(y_valid), 1);
            chk("bp_score", int'(y_score), 35);
            chk("bp_class", int'(y_class), 1);
        end
        hs("bp_hs");
        s_data = 8'sd1;
        tick();
        s_data = 8'sd1;
        tick();
        s_valid = 1'b0;
        chk("bp_next_yv", int'(y_valid), 1);
        chk("bp_next_score", int'(y_score), 13);
        hs("bp_next");

        // Write to w1 coincident with the beat that uses w1.
        s_valid = 1'b1;
        s_data  = 8'sd2;
        tick();
        s_data    = 8'sd3;
        w_wr_en   = 1'b1;
        w_wr_addr = 2'd1;
        w_wr_data = 8'sd1;
        tick();
        w_wr_en = 1'b0;
        s_valid = 1'b0;
        chk("coll_score", int'(y_score), 35);
        hs("coll_hs");
        run_sample("coll_next", 2, 3, 11, 1);

        // Reset after the first beat.
        load(4, 9, 0);
        s_valid = 1'b1;
        s_data  = 8'sd1;
        tick();
        s_valid = 1'b0;
        chk("rmid_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        chk("rmid_busy", int'(busy), 0);
        chk("rmid_yv", int'(y_valid), 0);
        chk("rmid_cnt", int'(sample_cnt), 0);
        run_sample("rmid_zero_w", 1, 2, 0, 0);
        load(4, 9, 0);
        run_sample("rmid_reload", 1, 2, 22, 1);

        // Reset coincident with a result handshake: reset wins.
        run_sample("pre_rhs", 2, 3, 35, 1);
        s_valid = 1'b1;
        s_data  = 8'sd2;
        tick();
        s_data = 8'sd3;
        tick();
        s_valid = 1'b0;
        chk("rhs_yv_pre", int'(y_valid), 1);
        y_ready = 1'b1;
        rst_n   = 1'b0;
        tick();
        rst_n   = 1'b1;
        y_ready = 1'b0;
        exp_cnt = 0;
        chk("rhs_yv", int'(y_valid), 0);
        chk("rhs_cnt", int'(sample_cnt), 0);

        // Single-feature instance: score = bias + w0*x, counter wraps at 16.
        w2_wr_en = 1'b1; w2_wr_addr = 1'b0; w2_wr_data = 8'sd2;
        tick();
        w2_wr_addr = 1'b1; w2_wr_data = 8'sd3;
        tick();
        w2_wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s2_valid = 1'b1;
            s2_data  = 8'sd5;
            tick();
            s2_valid = 1'b0;
            if (i == 0) begin
                chk("small_yv", int'(y2_valid), 1);
                chk("small_score", int'(y2_score), 13);
                chk("small_class", int'(y2_class), 1);
            end
            y2_ready = 1'b1;
            tick();
            y2_ready = 1'b0;
            if (i == 14) chk("small_cnt15", int'(sample_cnt2), 15);
        end
        chk("small_wrap", int'(sample_cnt2), 0);
        chk("small_srdy", int'(s2_ready), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
